// File: rtl/fsqrt_sequencer.sv
// fsqrt_sequencer: control FSM for an iterative square-root datapath.
// Walks LOAD -> ITER (ITER_STEPS cycles) -> NORM -> ROUND -> DONE and raises one
// datapath strobe per phase. A negative operand short-cuts to a single-cycle ERR
// pulse. All outputs are Moore-decoded from the registered state and step counter.
//
// Optional feature: define FSQRT_SEQ_EARLY_EXIT_EN to let rem_zero end the
// iteration phase early (ITER -> NORM with step frozen). Without the macro,
// rem_zero is ignored and ITER always runs exactly ITER_STEPS cycles.
module fsqrt_sequencer #(
    parameter int unsigned ITER_STEPS = 24,
    parameter int unsigned CNT_W      = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             negative,
    input  logic             abort,
    input  logic             rem_zero,
    output logic             busy,
    output logic             load_en,
    output logic             iter_en,
    output logic             norm_en,
    output logic             round_en,
    output logic [CNT_W-1:0] step,
    output logic             done,
    output logic             error
);

    // State encodings; 3'b111 is unused and falls back to IDLE.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_ITER  = 3'd2;
    localparam logic [2:0] ST_NORM  = 3'd3;
    localparam logic [2:0] ST_ROUND = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;
    localparam logic [2:0] ST_ERR   = 3'd6;

    // Index of the final iteration cycle.
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(ITER_STEPS - 1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] step_q, step_d;
    logic             early_exit;

`ifdef FSQRT_SEQ_EARLY_EXIT_EN
    assign early_exit = rem_zero;
`else
    // Hint input is deliberately ignored in this build.
    logic unused_rem_zero;
    assign unused_rem_zero = rem_zero;
    assign early_exit      = 1'b0;
`endif

    // Next-state and step-counter logic.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        if (abort && (state_q != ST_IDLE)) begin
            // Cancel drops straight to IDLE; no done/error pulse is produced.
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // abort only matters here by blocking a simultaneous start.
                    if (start && !abort) begin
                        state_d = negative ? ST_ERR : ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    step_d  = '0;
                    state_d = ST_ITER;
                end
                ST_ITER: begin
                    if (early_exit || (step_q == LAST_STEP)) begin
                        // Step keeps its final value through NORM/ROUND/DONE.
                        state_d = ST_NORM;
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end
                ST_NORM:  state_d = ST_ROUND;
                ST_ROUND: state_d = ST_DONE;
                ST_DONE:  state_d = ST_IDLE;
                ST_ERR:   state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // State and step registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
        end
    end

    // Moore output decode: every strobe is a pure function of the state register.
    always_comb begin
        busy     = (state_q != ST_IDLE);
        load_en  = 1'b0;
        iter_en  = 1'b0;
        norm_en  = 1'b0;
        round_en = 1'b0;
        done     = 1'b0;
        error    = 1'b0;
        case (state_q)
            ST_LOAD:  load_en  = 1'b1;
            ST_ITER:  iter_en  = 1'b1;
            ST_NORM:  norm_en  = 1'b1;
            ST_ROUND: round_en = 1'b1;
            ST_DONE:  done     = 1'b1;
            ST_ERR:   error    = 1'b1;
            default:  ;
        endcase
    end

    assign step = step_q;

    // Phase strobes are mutually exclusive by construction of the decode.
    a_strobes_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0({load_en, iter_en, norm_en, round_en, done, error}));

endmodule

// File: tb/tb_fsqrt_sequencer.sv
// Directed self-checking bench for fsqrt_sequencer (ITER_STEPS = 24, CNT_W = 5).
// Inputs change 1 ns after a rising edge; outputs are sampled at that same point,
// so after the k-th tick the bench observes the cycle that follows edge k.
module tb_fsqrt_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       negative;
    logic       abort;
    logic       rem_zero;
    logic       busy;
    logic       load_en;
    logic       iter_en;
    logic       norm_en;
    logic       round_en;
    logic [4:0] step;
    logic       done;
    logic       error;

    int checks = 0;
    int errors = 0;

    fsqrt_sequencer #(
        .ITER_STEPS(24),
        .CNT_W     (5)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .negative(negative),
        .abort   (abort),
        .rem_zero(rem_zero),
        .busy    (busy),
        .load_en (load_en),
        .iter_en (iter_en),
        .norm_en (norm_en),
        .round_en(round_en),
        .step    (step),
        .done    (done),
        .error   (error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset values while asserted and after release at a non-edge time.
    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; negative = 1'b0; abort = 1'b0; rem_zero = 1'b0;
        #12;
        checks++;
        if ({busy, load_en, iter_en, norm_en, round_en, done, error} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 0000000",
                     {busy, load_en, iter_en, norm_en, round_en, done, error});
        end
        checks++;
        if (step !== 5'd0) begin
            errors++;
            $display("FAIL reset_step: got %0d expected 0", step);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle: busy got %b expected 0", busy);
        end
    endtask

    // Full nominal operation with cycle-exact phase checks.
    task automatic test_normal();
        start = 1'b1; negative = 1'b0;
        tick();
        start = 1'b0;
        checks++;
        if (!(load_en === 1'b1 && busy === 1'b1 && iter_en === 1'b0)) begin
            errors++;
            $display("FAIL normal_load: load_en=%b busy=%b iter_en=%b expected 1 1 0",
                     load_en, busy, iter_en);
        end
        for (int i = 0; i < 24; i++) begin
            tick();
            checks++;
            if (!(iter_en === 1'b1 && step === 5'(i) && load_en === 1'b0
                  && norm_en === 1'b0)) begin
                errors++;
                $display("FAIL normal_iter[%0d]: iter_en=%b step=%0d expected 1 %0d",
                         i, iter_en, step, i);
            end
        end
        tick();
        checks++;
        if (!(norm_en === 1'b1 && iter_en === 1'b0 && step === 5'd23)) begin
            errors++;
            $display("FAIL normal_norm: norm_en=%b iter_en=%b step=%0d expected 1 0 23",
                     norm_en, iter_en, step);
        end
        tick();
        checks++;
        if (!(round_en === 1'b1 && norm_en === 1'b0)) begin
            errors++;
            $display("FAIL normal_round: round_en=%b norm_en=%b expected 1 0",
                     round_en, norm_en);
        end
        tick();
        checks++;
        if (!(done === 1'b1 && round_en === 1'b0 && busy === 1'b1)) begin
            errors++;
            $display("FAIL normal_done: done=%b round_en=%b busy=%b expected 1 0 1",
                     done, round_en, busy);
        end
        tick();
        checks++;
        if (!(done === 1'b0 && busy === 1'b0)) begin
            errors++;
            $display("FAIL normal_idle_after: done=%b busy=%b expected 0 0", done, busy);
        end
    endtask

    // Negative operand: single error pulse, no load.
    task automatic test_error();
        start = 1'b1; negative = 1'b1;
        tick();
        start = 1'b0; negative = 1'b0;
        checks++;
        if (!(error === 1'b1 && busy === 1'b1 && load_en === 1'b0)) begin
            errors++;
            $display("FAIL error_pulse: error=%b busy=%b load_en=%b expected 1 1 0",
                     error, busy, load_en);
        end
        tick();
        checks++;
        if (!(error === 1'b0 && busy === 1'b0 && load_en === 1'b0)) begin
            errors++;
            $display("FAIL error_after: error=%b busy=%b load_en=%b expected 0 0 0",
                     error, busy, load_en);
        end
    endtask

    // Abort mid-iteration, abort vs start in IDLE, then a clean rerun.
    task automatic test_abort();
        int seen_pulse;
        start = 1'b1; negative = 1'b0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 11; i++) tick();
        checks++;
        if (!(iter_en === 1'b1 && step === 5'd10)) begin
            errors++;
            $display("FAIL abort_at_step10: iter_en=%b step=%0d expected 1 10", iter_en, step);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: busy got %b expected 0", busy);
        end
        seen_pulse = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (done === 1'b1 || error === 1'b1 || busy === 1'b1) seen_pulse++;
        end
        checks++;
        if (seen_pulse != 0) begin
            errors++;
            $display("FAIL abort_no_done: active cycles got %0d expected 0", seen_pulse);
        end
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        checks++;
        if (!(busy === 1'b0 && load_en === 1'b0)) begin
            errors++;
            $display("FAIL abort_wins_idle: busy=%b load_en=%b expected 0 0", busy, load_en);
        end
        test_normal();
    endtask

    // Asynchronous reset in the middle of an operation.
    task automatic test_reset_mid();
        int seen_pulse;
        start = 1'b1; negative = 1'b0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if (step !== 5'd5) begin
            errors++;
            $display("FAIL rstmid_step5: step got %0d expected 5", step);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, load_en, iter_en, norm_en, round_en, done, error} !== 7'b0
            || step !== 5'd0) begin
            errors++;
            $display("FAIL rstmid_async: outputs=%b step=%0d expected 0000000 0",
                     {busy, load_en, iter_en, norm_en, round_en, done, error}, step);
        end
        #2 rst_n = 1'b1;
        seen_pulse = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (done === 1'b1 || error === 1'b1 || busy === 1'b1) seen_pulse++;
        end
        checks++;
        if (seen_pulse != 0) begin
            errors++;
            $display("FAIL rstmid_idle_after: active cycles got %0d expected 0", seen_pulse);
        end
    endtask

    // rem_zero asserted at step 7: early NORM if enabled, otherwise ignored.
    task automatic test_early_exit();
        start = 1'b1; negative = 1'b0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        checks++;
        if (step !== 5'd7) begin
            errors++;
            $display("FAIL early_step7: step got %0d expected 7", step);
        end
        rem_zero = 1'b1;
`ifdef FSQRT_SEQ_EARLY_EXIT_EN
        tick();
        rem_zero = 1'b0;
        checks++;
        if (!(norm_en === 1'b1 && step === 5'd7)) begin
            errors++;
            $display("FAIL early_norm: norm_en=%b step=%0d expected 1 7", norm_en, step);
        end
        tick();
        checks++;
        if (round_en !== 1'b1) begin
            errors++;
            $display("FAIL early_round: round_en got %b expected 1", round_en);
        end
        tick();
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL early_done: done got %b expected 1", done);
        end
        tick();
`else
        for (int i = 8; i < 24; i++) begin
            tick();
            checks++;
            if (!(iter_en === 1'b1 && step === 5'(i))) begin
                errors++;
                $display("FAIL noearly_iter[%0d]: iter_en=%b step=%0d expected 1 %0d",
                         i, iter_en, step, i);
            end
        end
        tick();
        rem_zero = 1'b0;
        checks++;
        if (!(norm_en === 1'b1 && step === 5'd23)) begin
            errors++;
            $display("FAIL noearly_norm: norm_en=%b step=%0d expected 1 23", norm_en, step);
        end
        tick();
        tick();
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL noearly_done: done got %b expected 1", done);
        end
        tick();
`endif
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL early_idle_after: busy got %b expected 0", busy);
        end
    endtask

    // start held high: one IDLE cycle between operations; pulses while busy ignored.
    task automatic test_back_to_back();
        int n_ticks;
        int n_done;
        start = 1'b1; negative = 1'b0;
        tick();
        n_ticks = 0;
        while (done !== 1'b1 && n_ticks < 40) begin
            tick();
            n_ticks++;
        end
        checks++;
        if (n_ticks != 27) begin
            errors++;
            $display("FAIL b2b_latency: ticks after load got %0d expected 27", n_ticks);
        end
        tick();
        checks++;
        if (!(busy === 1'b0 && load_en === 1'b0)) begin
            errors++;
            $display("FAIL b2b_gap_idle: busy=%b load_en=%b expected 0 0", busy, load_en);
        end
        tick();
        checks++;
        if (load_en !== 1'b1) begin
            errors++;
            $display("FAIL b2b_restart: load_en got %b expected 1", load_en);
        end
        start = 1'b0; abort = 1'b1;
        tick();
        abort = 1'b0;
        // Error path with start and negative held: ERR, IDLE, ERR.
        start = 1'b1; negative = 1'b1;
        tick();
        checks++;
        if (error !== 1'b1) begin
            errors++;
            $display("FAIL b2b_err_first: error got %b expected 1", error);
        end
        tick();
        checks++;
        if (!(error === 1'b0 && busy === 1'b0)) begin
            errors++;
            $display("FAIL b2b_err_gap: error=%b busy=%b expected 0 0", error, busy);
        end
        tick();
        checks++;
        if (error !== 1'b1) begin
            errors++;
            $display("FAIL b2b_err_again: error got %b expected 1", error);
        end
        start = 1'b0; negative = 1'b0;
        tick();
        // Single operation with extra start pulses while busy.
        start = 1'b1;
        tick();
        start = 1'b0;
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            start = (i < 20 && (i % 3) == 0);
            tick();
            if (done === 1'b1) n_done++;
        end
        start = 1'b0;
        checks++;
        if (!(n_done == 1 && busy === 1'b0)) begin
            errors++;
            $display("FAIL b2b_pulses_ignored: done count=%0d busy=%b expected 1 0",
                     n_done, busy);
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_error();
        test_abort();
        test_reset_mid();
        test_early_exit();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fsqrt_sequencer.md
FSQRT_SEQUENCER -- requirements
Module: fsqrt_sequencer

Interface
REQ-001 Parameter ITER_STEPS, default 24: number of root-iteration cycles per operation; legal range 2..256.
REQ-002 Parameter CNT_W, default 5: width of the step counter; SHALL satisfy 2^CNT_W >= ITER_STEPS.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  operation request, sampled only in IDLE.
REQ-006 negative  input  1  operand sign flag, sampled with start.
REQ-007 abort  input  1  cancel the operation in progress.
REQ-008 rem_zero  input  1  datapath partial remainder is zero (early-exit hint).
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 load_en, iter_en, norm_en, round_en  output  1 each  datapath strobes, one per phase.
REQ-011 step  output  CNT_W  current iteration index.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 error  output  1  one-cycle negative-operand pulse.

Function
REQ-014 Moore FSM with states IDLE, LOAD, ITER, NORM, ROUND, DONE, ERR; all outputs SHALL decode from registered state and step only.
REQ-015 IDLE: start=1 and negative=0 -> LOAD; start=1 and negative=1 -> ERR; otherwise remain in IDLE.
REQ-016 LOAD: load_en=1 for one cycle, step cleared to 0, then -> ITER.
REQ-017 ITER: iter_en=1 every cycle; step increments by 1 each cycle; at step==ITER_STEPS-1 -> NORM, with step holding its final value.
REQ-018 NORM: norm_en=1 for one cycle -> ROUND; ROUND: round_en=1 for one cycle -> DONE.
REQ-019 DONE: done=1 for one cycle -> IDLE; ERR: error=1 for one cycle -> IDLE.
REQ-020 Latency: with start sampled at edge k, done SHALL be high in the cycle following edge k+ITER_STEPS+3.
REQ-021 start arriving while busy=1 SHALL be ignored, with no queuing.
REQ-022 abort=1 in any state other than IDLE SHALL force IDLE at the next edge, with no done or error pulse; abort in IDLE has no effect.
REQ-023 If start and abort are both high in IDLE, abort SHALL win and the FSM SHALL remain in IDLE.
REQ-024 Back-to-back operation: start held high while in DONE or ERR SHALL be ignored; a new operation begins only when start is sampled in IDLE.
REQ-025 Unreachable state encodings SHALL return to IDLE at the next edge.
REQ-026 At most one of load_en, iter_en, norm_en, round_en, done, error SHALL be high in any cycle.

Reset
REQ-027 rst_n=0 SHALL immediately force state=IDLE and step=0.
REQ-028 While rst_n=0, busy, all strobes, done and error SHALL be 0.
REQ-029 Reset asserted mid-operation SHALL abandon the operation with no done or error pulse.
REQ-030 The first state transition SHALL occur at the first rising edge after rst_n deasserts.

Configuration
REQ-031 Macro FSQRT_SEQ_EARLY_EXIT_EN defined: in ITER, rem_zero=1 SHALL cause ITER -> NORM at the next edge, with step frozen at its current value.
REQ-032 Macro FSQRT_SEQ_EARLY_EXIT_EN undefined: rem_zero SHALL be ignored and ITER SHALL always run exactly ITER_STEPS cycles.

Verification
REQ-033 ITER_STEPS=24, start=1 with negative=0 at edge 0 -> load_en in cycle 1, iter_en in cycles 2..25 with step 0..23, norm_en in cycle 26, round_en in cycle 27, done in cycle 28.
REQ-034 start=1 with negative=1 -> error=1 for exactly one cycle, then busy=0; no load_en.
REQ-035 abort=1 at step=10 -> busy=0 at the next edge; done never asserts; a following start runs the full sequence normally.
REQ-036 rst_n pulsed low at step=5 -> all outputs 0 immediately (asynchronously); state IDLE after release.
REQ-037 Macro defined, rem_zero=1 at step=7 -> norm_en at the next cycle, done 3 cycles later; macro undefined, same stimulus -> full 24 iterations.
REQ-038 start held high continuously -> operations separated by exactly one IDLE cycle; start pulses while busy produce no extra done.
